// File: rtl/coord_pkg.sv
// Shared constants, FSM encoding and the width-to-coordinate mapping for the
// servo PWM coordinate capture block.
package coord_pkg;
  localparam int COORD_W      = 10;
  localparam int COORD_MAX    = 1023;
  localparam int CNT_W        = 16;
  localparam int DEF_PRESCALE = 50;
  localparam int DEF_OFFSET   = 1000;
  localparam int DEF_MAX_HIGH = 3000;
  localparam int DEF_TIMEOUT  = 25000;

  typedef enum logic [1:0] {WAIT_LOW, WAIT_HIGH, HIGH} meter_state_t;

  // Signed subtraction so short pulses clamp to 0 instead of wrapping.
  function automatic logic [COORD_W-1:0] width_to_coord(
    input logic        [CNT_W-1:0] width,
    input logic signed [CNT_W:0]   offset
  );
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, width}) - offset;
    if (diff < 0)              return '0;
    else if (diff > COORD_MAX) return COORD_W'(COORD_MAX);
    else                       return diff[COORD_W-1:0];
  endfunction
endpackage

// File: rtl/pwm_channel_meter.sv
// One PWM channel: synchroniser, edge detect, pulse-width FSM, timeout and
// the shadow coordinate/valid pair sampled by the frame latch.
module pwm_channel_meter
  import coord_pkg::*;
#(
  parameter int OFFSET   = DEF_OFFSET,
  parameter int MAX_HIGH = DEF_MAX_HIGH,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic               pwm_i,
  output logic [COORD_W-1:0] coord_o,
  output logic               valid_o
);
  localparam logic signed [CNT_W:0] OFF_S = (CNT_W+1)'(OFFSET);
  localparam logic [CNT_W-1:0]      MAX_W = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0]      TO_W  = CNT_W'(TIMEOUT);

  logic sync1_q, sync2_q, prev_q, rise_q, fall_q;
  meter_state_t state_q, state_d;
  logic [CNT_W-1:0]   width_q, width_d, to_q, to_d;
  logic [COORD_W-1:0] shadow_q, shadow_d;
  logic               svalid_q, svalid_d;
  logic               over_max;

  // Sync stages reset high so a pulse already in progress at reset release
  // never looks like a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= ~sync2_q & prev_q;
    end
  end

  assign over_max = (width_q > MAX_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_LOW;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOW:  if (!sync2_q) state_d = WAIT_HIGH;
      WAIT_HIGH: if (rise_q)   state_d = HIGH;
      HIGH: begin
        if (over_max)    state_d = WAIT_LOW;
        else if (fall_q) state_d = WAIT_HIGH;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_comb begin
    width_d  = width_q;
    shadow_d = shadow_q;
    svalid_d = svalid_q;
    to_d     = to_q;
    case (state_q)
      WAIT_HIGH: if (rise_q) width_d = '0;
      HIGH: begin
        if (over_max) svalid_d = 1'b0;
        else if (fall_q) begin
          shadow_d = width_to_coord(width_q, OFF_S);
          svalid_d = 1'b1;
        end else if (tick_i && width_q != '1) width_d = width_q + CNT_W'(1);
      end
      default: ;
    endcase
    // A rise in the same cycle as expiry wins and leaves valid alone.
    if (rise_q)             to_d = '0;
    else if (to_q == TO_W)  svalid_d = 1'b0;
    else if (tick_i)        to_d = to_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q  <= '0;
      to_q     <= '0;
      shadow_q <= '0;
      svalid_q <= 1'b0;
    end else begin
      width_q  <= width_d;
      to_q     <= to_d;
      shadow_q <= shadow_d;
      svalid_q <= svalid_d;
    end
  end

  assign coord_o = shadow_q;
  assign valid_o = svalid_q;
endmodule

// File: rtl/pwm_coord_capture.sv
// Three-channel servo PWM to coordinate converter; results are latched on the
// VGA frame tick so the overlay sees values that are stable for a whole frame.
module pwm_coord_capture
  import coord_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int OFFSET   = DEF_OFFSET,
  parameter int MAX_HIGH = DEF_MAX_HIGH,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         pwm_in,
  input  logic               frame_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] z,
  output logic [2:0]         valid,
  output logic               sample_stb
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]           ps_q;
  logic                      tick;
  logic [2:0][COORD_W-1:0]   coord;
  logic [2:0]                svalid;
  logic [COORD_W-1:0]        x_q, y_q, z_q;
  logic [2:0]                valid_q;
  logic                      ft_q, stb_q;

  // Free-running; never realigned to PWM edges.
  assign tick = (ps_q == PS_W'(PRESCALE-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ps_q <= '0;
    else if (tick) ps_q <= '0;
    else           ps_q <= ps_q + PS_W'(1);
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    pwm_channel_meter #(
      .OFFSET  (OFFSET),
      .MAX_HIGH(MAX_HIGH),
      .TIMEOUT (TIMEOUT)
    ) u_meter (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .pwm_i  (pwm_in[i]),
      .coord_o(coord[i]),
      .valid_o(svalid[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      valid_q <= '0;
      ft_q    <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      ft_q  <= frame_tick;
      stb_q <= ft_q;
      if (frame_tick) begin
        x_q     <= coord[0];
        y_q     <= coord[1];
        z_q     <= coord[2];
        valid_q <= svalid;
      end
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign z          = z_q;
  assign valid      = valid_q;
  assign sample_stb = stb_q;
endmodule

// File: doc/pwm_coord_capture.md
# pwm_coord_capture

Measures the high-time of the three servo PWM signals driving the robotic arm (X, Y, Z joints) and converts each to a 10-bit coordinate (0–1023). It sits directly upstream of the VGA coordinate text overlay and feeds its `x`, `y` and `z` inputs. Results are double-buffered and only change on the VGA frame tick, so the overlay never shows a value that changes partway through a frame.

## Interface
Parameters:
- `PRESCALE`, 50: clocks per measurement tick (1 µs at 50 MHz).
- `OFFSET`, 1000: ticks subtracted from the measured high-time before clamping.
- `MAX_HIGH`, 3000: high-time in ticks above which a pulse is rejected as stuck or glitched.
- `TIMEOUT`, 25000: ticks without a rising edge before a channel is declared invalid.

Ports:
- `clk` input, 1 bit: system clock. Single clock domain.
- `rst` input, 1 bit: reset, **asynchronous, active-high**.
- `pwm_in` input, 3 bits: raw PWM signals, asynchronous to `clk`. Bit 0 = X, bit 1 = Y, bit 2 = Z.
- `frame_tick` input, 1 bit: one-cycle pulse from VGA timing at the start of vertical blanking.
- `x` output, 10 bits: displayed X coordinate.
- `y` output, 10 bits: displayed Y coordinate.
- `z` output, 10 bits: displayed Z coordinate.
- `valid` output, 3 bits: per-channel signal-present flag, latched together with `x`, `y` and `z`.
- `sample_stb` output, 1 bit: one-cycle pulse, asserted the cycle after `x`/`y`/`z`/`valid` are updated.

## Operation
- **Input conditioning:** each `pwm_in` bit passes through a 2-FF synchroniser and then a registered edge detector, giving rise and fall pulses.
- **Prescaler:** one shared, free-running counter of 0..`PRESCALE`-1. It emits `tick` when it wraps and is never reset by PWM edges, so measurements carry ±1 tick of quantisation.
- **Per-channel FSM** (states `WAIT_LOW`, `WAIT_HIGH`, `HIGH`):
  - `WAIT_LOW`: entered at reset. Leaves to `WAIT_HIGH` when the synchronised input is low. This prevents measuring a partial pulse.
  - `WAIT_HIGH`: on rise, clear the width counter and go to `HIGH`.
  - `HIGH`, on each `tick`: increment the width counter (16 bits, saturating at 65535).
  - `HIGH`, on fall: compute `coord = clamp(width − OFFSET, 0, 1023)`, write it to the shadow value, set shadow valid, and go to `WAIT_HIGH`.
  - `HIGH`, if width exceeds `MAX_HIGH`: clear shadow valid, keep the shadow value, and go to `WAIT_LOW`.
- **Arithmetic:** the subtraction is done at 17 bits signed. A negative result gives 0; a result above 1023 gives 1023. A width exactly equal to `OFFSET` gives 0; `OFFSET`+1023 gives 1023.
- **Timeout:**
  - A per-channel 16-bit counter is cleared on every rise and incremented on each `tick`.
  - When it reaches `TIMEOUT`, shadow valid is cleared and the counter holds (saturates). The state is unchanged and the shadow value is kept.
- **Frame latch:** on `frame_tick`, `x`/`y`/`z`/`valid` load from the shadow registers in a single cycle, and `sample_stb` pulses on the next cycle.
- **Simultaneous events:**
  - If a shadow update and `frame_tick` fall in the same cycle, the output takes the pre-update shadow. The new value appears on the following frame.
  - If rise and timeout occur in the same cycle, the rise wins: the counter clears and valid is untouched.
- **Reset**, asynchronous and at any point including mid-pulse, clears:
  - all FSMs to `WAIT_LOW`;
  - all counters, shadow values and shadow valids;
  - outputs: `x`=`y`=`z`=0, `valid`=0, `sample_stb`=0.

## Timing
- Latency from a `pwm_in` edge to the rise/fall pulse: 3 clocks (2 synchroniser + 1 edge register).
- Latency from the fall pulse to the shadow update: 1 clock.
- Latency from `frame_tick` to a new output value: 1 clock.
- Latency from `frame_tick` to `sample_stb`: 2 clocks.
- Outputs are registered and stable for a whole frame, so the downstream overlay uses them combinationally without any handshake.
- Minimum measurable pulse: 1 tick. Pulses shorter than 2 clocks are not guaranteed to be detected.

## Structure
- Shared package `coord_pkg`, containing:
  - `COORD_W` = 10, `COORD_MAX` = 1023;
  - the FSM state enum `meter_state_t`;
  - default parameter constants.
- Sub-module `pwm_channel_meter`, instantiated three times. It contains the synchroniser, edge detector, FSM, width and timeout counters, and shadow value/valid. It takes `tick` from the parent.
- The top level holds the prescaler, the frame latch and `sample_stb`.

## Test plan
All scenarios use `PRESCALE`=50, `OFFSET`=1000, `MAX_HIGH`=3000, `TIMEOUT`=25000, and a `frame_tick` every 16.7 ms.
- Reset with 1500 µs pulses every 20 ms on all channels → `x`=`y`=`z`=500±1 and `valid`=3'b111 after the first `frame_tick` that follows a complete pulse. Outputs read 0 before that.
- Release reset mid-pulse with X high → that partial pulse is ignored, and the first `x` reported comes from the next full pulse.
- Clamp check on X:
  - 900 µs → `x`=0;
  - 2100 µs → `x`=1023;
  - 1000 µs → `x`=0±1;
  - 2023 µs → `x`=1023.
- Stop toggling Y (held low) for 30 ms → `valid[1]`=0 at the next `frame_tick`, and `y` holds its last value. Restarting 1200 µs pulses → `valid[1]`=1 and `y`=200±1.
- Hold Z high for 4 ms → `valid[2]`=0, and no update happens until Z goes low and a fresh 1700 µs pulse arrives, giving `z`=700±1.
- Fire the X fall (a new 1800 µs pulse, previous value 500) in the same cycle the shadow updates coincide with `frame_tick` → `x`=500 for that frame and 800±1 on the next frame. `sample_stb` is a single-cycle pulse 2 clocks after each `frame_tick`.
